trigger_bank: RTL and testbench
===============================

// Module: trigger_bank
// PURPOSE
//   Bank of three independent edge-triggered storage elements sharing one clock and reset:
//   a D flip-flop, a JK flip-flop and an RS (set/reset) flip-flop, each WIDTH bits wide.
//   It is the team's reference sequential primitive set; other blocks instantiate it for
//   registered control bits. Each bit lane is fully independent of the others.
// PARAMETERS
//   WIDTH    1    bit width of every data input and every output (one flip-flop per bit)
// PORTS
//   clk      in   1      single clock; all state updates on the rising edge
//   rst_n    in   1      asynchronous reset, active-low
//   D        in   WIDTH  D flip-flop data input
//   J        in   WIDTH  JK flip-flop J input
//   K        in   WIDTH  JK flip-flop K input
//   R        in   WIDTH  RS flip-flop reset input
//   S        in   WIDTH  RS flip-flop set input
//   q_d      out  WIDTH  D flip-flop state
//   q_jk     out  WIDTH  JK flip-flop state
//   q_rs     out  WIDTH  RS flip-flop state
//   rs_both  out  WIDTH  registered flag: R and S were both 1 at the last edge
// BEHAVIOUR
//   - Reset: rst_n=0 forces q_d, q_jk, q_rs and rs_both to 0 immediately, regardless of clk.
//     Reset dominates every other input. Release is asynchronous; the first update occurs
//     at the first rising clk edge with rst_n=1.
//   - All outputs come straight from flops; no combinational path from inputs to outputs.
//     Latency: 1 clock edge from input change to output.
//   - D:  q_d <= D.
//   - JK (per bit): J=0,K=0 hold; J=0,K=1 -> 0; J=1,K=0 -> 1; J=1,K=1 -> toggle (~q_jk).
//     Toggle repeats on every edge while J=K=1.
//   - RS (per bit): R=0,S=0 hold; R=0,S=1 -> 1; R=1,S=0 -> 0; R=1,S=1 -> hold q_rs
//     (the illegal combination is defined as hold) and rs_both <= 1.
//     rs_both <= (R & S) on every edge, so it clears on the next edge without R=S=1.
//   - Inputs are sampled only at rising clk edges; glitches between edges have no effect.
//   - X/Z on inputs is not defined; the bench drives known values only.
// STRUCTURE
//   - Package trigger_pkg: typedef enum logic [1:0] jk_cmd_e {JK_HOLD=2'b00, JK_RESET=2'b01,
//     JK_SET=2'b10, JK_TOGGLE=2'b11} (index {J,K}); an RS equivalent rs_cmd_e {S,R} with
//     RS_HOLD, RS_CLR, RS_SET, RS_BOTH; pure function next_jk(cmd, q).
//   - One sub-module trigger_cell: a 1-bit cell holding the D, JK and RS flops plus the
//     rs_both flag. trigger_bank instantiates WIDTH copies in a generate loop.
// TESTING
//   1. rst_n=0 with D=J=K=R=S=1 and clk running -> all outputs 0 throughout; after rst_n=1
//      the first edge gives q_d=1, q_jk=1, q_rs=0 (R=S=1 held), rs_both=1.
//   2. WIDTH=1, all inputs 0 for 2 edges -> q_d=q_jk=q_rs=0; then J=0,K=1,R=0,S=1 -> after
//      1 edge q_jk=0, q_rs=1.
//   3. J=1,K=0,R=1,S=0,D=1 -> after 1 edge q_jk=1, q_rs=0, q_d=1.
//   4. J=K=1 for 4 edges starting from q_jk=1 -> q_jk follows 0,1,0,1.
//      R=S=1 -> q_rs holds 0 and rs_both=1; drop S -> rs_both=0 on the next edge.
//   5. Assert rst_n=0 midway between edges while q_jk is toggling -> outputs drop to 0
//      before the next edge.
//   6. WIDTH=4, J=4'b1010, K=4'b0110 from q_jk=4'b0000 -> after 1 edge q_jk=4'b1010; then
//      J=K=4'b1111 -> 4'b0101.
//      D=4'b1100 -> after 1 edge q_d=4'b1100.

Source files
------------

// File: rtl/trigger_pkg.sv
// Shared command encodings and next-state helpers for the trigger bank flip-flops.
// The JK command is indexed {J,K}, and the RS command is indexed {S,R}.
package trigger_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_cmd_e;

    typedef enum logic [1:0] {
        RS_HOLD = 2'b00,
        RS_CLR  = 2'b01,
        RS_SET  = 2'b10,
        RS_BOTH = 2'b11
    } rs_cmd_e;

    function automatic logic next_jk(input jk_cmd_e cmd, input logic q);
        logic q_next;
        q_next = q;
        case (cmd)
            JK_HOLD:   q_next = q;
            JK_RESET:  q_next = 1'b0;
            JK_SET:    q_next = 1'b1;
            JK_TOGGLE: q_next = ~q;
            default:   q_next = q;
        endcase
        return q_next;
    endfunction

    // The forbidden R=S=1 combination keeps the stored value.
    function automatic logic next_rs(input rs_cmd_e cmd, input logic q);
        logic q_next;
        q_next = q;
        case (cmd)
            RS_HOLD: q_next = q;
            RS_CLR:  q_next = 1'b0;
            RS_SET:  q_next = 1'b1;
            RS_BOTH: q_next = q;
            default: q_next = q;
        endcase
        return q_next;
    endfunction

endpackage

// File: rtl/trigger_cell.sv
// One bit lane of the trigger bank: a D, a JK and an RS flip-flop, plus the
// registered R&S flag. All of these elements share the asynchronous active-low reset.
module trigger_cell
    import trigger_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    input  logic i_j,
    input  logic i_k,
    input  logic i_r,
    input  logic i_s,
    output logic o_q_d,
    output logic o_q_jk,
    output logic o_q_rs,
    output logic o_rs_both
);

    logic    r_q_d;
    logic    r_q_jk;
    logic    r_q_rs;
    logic    r_rs_both;
    jk_cmd_e w_jk_cmd;
    rs_cmd_e w_rs_cmd;
    logic    w_q_jk_next;
    logic    w_q_rs_next;

    assign w_jk_cmd    = jk_cmd_e'({i_j, i_k});
    assign w_rs_cmd    = rs_cmd_e'({i_s, i_r});
    assign w_q_jk_next = next_jk(w_jk_cmd, r_q_jk);
    assign w_q_rs_next = next_rs(w_rs_cmd, r_q_rs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_d     <= 1'b0;
            r_q_jk    <= 1'b0;
            r_q_rs    <= 1'b0;
            r_rs_both <= 1'b0;
        end else begin
            r_q_d     <= i_d;
            r_q_jk    <= w_q_jk_next;
            r_q_rs    <= w_q_rs_next;
            r_rs_both <= i_r & i_s;
        end
    end

    assign o_q_d     = r_q_d;
    assign o_q_jk    = r_q_jk;
    assign o_q_rs    = r_q_rs;
    assign o_rs_both = r_rs_both;

endmodule

// File: rtl/trigger_bank.sv
// WIDTH independent trigger cells. Each cell holds a D, a JK and an RS flip-flop.
// Every output is driven directly by a flop.
module trigger_bank
    import trigger_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] R,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] q_d,
    output logic [WIDTH-1:0] q_jk,
    output logic [WIDTH-1:0] q_rs,
    output logic [WIDTH-1:0] rs_both
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            trigger_cell u_cell (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_d      (D[gi]),
                .i_j      (J[gi]),
                .i_k      (K[gi]),
                .i_r      (R[gi]),
                .i_s      (S[gi]),
                .o_q_d    (q_d[gi]),
                .o_q_jk   (q_jk[gi]),
                .o_q_rs   (q_rs[gi]),
                .o_rs_both(rs_both[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_trigger_bank.sv
// Self-checking bench for trigger_bank. It drives a 4-bit instance and a 1-bit instance.
// The 1-bit instance receives lane 0 of the same stimulus.
module tb_trigger_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] D, J, K, R, S;
    logic [3:0] q4_d, q4_jk, q4_rs, q4_both;
    logic       q1_d, q1_jk, q1_rs, q1_both;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    trigger_bank #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .D(D), .J(J), .K(K), .R(R), .S(S),
        .q_d(q4_d), .q_jk(q4_jk), .q_rs(q4_rs), .rs_both(q4_both)
    );

    trigger_bank #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .D(D[0]), .J(J[0]), .K(K[0]), .R(R[0]), .S(S[0]),
        .q_d(q1_d), .q_jk(q1_jk), .q_rs(q1_rs), .rs_both(q1_both)
    );

    typedef struct {
        logic [3:0] d, j, k, r, s;
        logic [3:0] e_d, e_jk, e_rs, e_both;
    } vec_t;

    vec_t vecs [17];

    // Reference state. It is updated from the flip-flop truth tables, one bit at a time.
    logic [3:0] m_d, m_jk, m_rs, m_both;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] ed, input logic [3:0] ejk,
                             input logic [3:0] ers, input logic [3:0] eb);
        chk({tag, ".q_d"},     q4_d,    ed);
        chk({tag, ".q_jk"},    q4_jk,   ejk);
        chk({tag, ".q_rs"},    q4_rs,   ers);
        chk({tag, ".rs_both"}, q4_both, eb);
        chk({tag, ".w1.q_d"},     {3'b0, q1_d},    {3'b0, ed[0]});
        chk({tag, ".w1.q_jk"},    {3'b0, q1_jk},   {3'b0, ejk[0]});
        chk({tag, ".w1.q_rs"},    {3'b0, q1_rs},   {3'b0, ers[0]});
        chk({tag, ".w1.rs_both"}, {3'b0, q1_both}, {3'b0, eb[0]});
    endtask

    task automatic drive(input logic [3:0] d, input logic [3:0] j, input logic [3:0] k,
                         input logic [3:0] r, input logic [3:0] s);
        D = d; J = j; K = k; R = r; S = s;
    endtask

    task automatic model_edge(input logic [3:0] d, input logic [3:0] j, input logic [3:0] k,
                              input logic [3:0] r, input logic [3:0] s);
        for (int i = 0; i < 4; i++) begin
            m_d[i] = d[i];
            if (j[i] && k[i])  m_jk[i] = !m_jk[i];
            else if (j[i])     m_jk[i] = 1'b1;
            else if (k[i])     m_jk[i] = 1'b0;
            if (s[i] && !r[i]) m_rs[i] = 1'b1;
            else if (r[i] && !s[i]) m_rs[i] = 1'b0;
            m_both[i] = r[i] & s[i];
        end
    endtask

    task automatic set_vec(input int idx, input logic [3:0] d, input logic [3:0] j,
                           input logic [3:0] k, input logic [3:0] r, input logic [3:0] s,
                           input logic [3:0] ed, input logic [3:0] ejk,
                           input logic [3:0] ers, input logic [3:0] eb);
        vecs[idx].d = d; vecs[idx].j = j; vecs[idx].k = k; vecs[idx].r = r; vecs[idx].s = s;
        vecs[idx].e_d = ed; vecs[idx].e_jk = ejk; vecs[idx].e_rs = ers; vecs[idx].e_both = eb;
    endtask

    initial begin
        logic [3:0] vd, vj, vk, vr, vs;
        bit         do_rst;

        // Directed sequence. It starts from a reset state.
        //          idx  D     J     K     R     S      q_d   q_jk  q_rs  both
        set_vec(0,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'h0, 4'h0);
        set_vec(1,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0,  4'h0, 4'h0, 4'h0, 4'h0);
        set_vec(2,  4'h0, 4'h0, 4'hF, 4'h0, 4'hF,  4'h0, 4'h0, 4'hF, 4'h0);
        set_vec(3,  4'hF, 4'hF, 4'h0, 4'hF, 4'h0,  4'hF, 4'hF, 4'h0, 4'h0);
        set_vec(4,  4'h0, 4'hF, 4'hF, 4'h0, 4'h0,  4'h0, 4'h0, 4'h0, 4'h0);
        set_vec(5,  4'h0, 4'hF, 4'hF, 4'h0, 4'h0,  4'h0, 4'hF, 4'h0, 4'h0);
        set_vec(6,  4'h0, 4'hF, 4'hF, 4'h0, 4'h0,  4'h0, 4'h0, 4'h0, 4'h0);
        set_vec(7,  4'h0, 4'hF, 4'hF, 4'h0, 4'h0,  4'h0, 4'hF, 4'h0, 4'h0);
        set_vec(8,  4'h0, 4'h0, 4'h0, 4'hF, 4'hF,  4'h0, 4'hF, 4'h0, 4'hF);
        set_vec(9,  4'h0, 4'h0, 4'h0, 4'hF, 4'h0,  4'h0, 4'hF, 4'h0, 4'h0);
        set_vec(10, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0,  4'h0, 4'h0, 4'h0, 4'h0);
        set_vec(11, 4'h0, 4'hA, 4'h6, 4'h0, 4'h0,  4'h0, 4'hA, 4'h0, 4'h0);
        set_vec(12, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0,  4'h0, 4'h5, 4'h0, 4'h0);
        set_vec(13, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0,  4'hC, 4'h5, 4'h0, 4'h0);
        set_vec(14, 4'h3, 4'h0, 4'h0, 4'h0, 4'h5,  4'h3, 4'h5, 4'h5, 4'h0);
        set_vec(15, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0,  4'h9, 4'h5, 4'h5, 4'h0);
        set_vec(16, 4'h0, 4'h0, 4'h0, 4'hF, 4'h3,  4'h0, 4'h5, 4'h1, 4'h3);

        // Reset with every input at 1 and the clock running.
        rst_n = 1'b0;
        drive(4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        #1 check_all("rst_pre_edge", 4'h0, 4'h0, 4'h0, 4'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_all("rst_held", 4'h0, 4'h0, 4'h0, 4'h0);
            $display("reset cycle %0d q_d=%h q_jk=%h q_rs=%h both=%h", c, q4_d, q4_jk, q4_rs, q4_both);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("rst_release", 4'hF, 4'hF, 4'h0, 4'hF);
        $display("release q_d=%h q_jk=%h q_rs=%h both=%h", q4_d, q4_jk, q4_rs, q4_both);

        // Apply a short reset, then run the directed table.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int v = 0; v < 17; v++) begin
            drive(vecs[v].d, vecs[v].j, vecs[v].k, vecs[v].r, vecs[v].s);
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", v), vecs[v].e_d, vecs[v].e_jk, vecs[v].e_rs, vecs[v].e_both);
            $display("vec %0d D=%h J=%h K=%h R=%h S=%h -> q_d=%h q_jk=%h q_rs=%h both=%h",
                     v, D, J, K, R, S, q4_d, q4_jk, q4_rs, q4_both);
        end

        // Assert reset midway between edges while q_jk is toggling (q_jk starts at 5).
        drive(4'h0, 4'hF, 4'hF, 4'h0, 4'h0);
        @(posedge clk); #1;
        check_all("tog0", 4'h0, 4'hA, 4'h1, 4'h0);
        @(posedge clk); #1;
        check_all("tog1", 4'h0, 4'h5, 4'h1, 4'h0);
        #3 rst_n = 1'b0;
        #1 check_all("mid_rst", 4'h0, 4'h0, 4'h0, 4'h0);
        $display("mid-cycle reset q_jk=%h", q4_jk);
        @(posedge clk); #1;
        check_all("mid_rst_hold", 4'h0, 4'h0, 4'h0, 4'h0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("mid_rst_rel", 4'h0, 4'hF, 4'h0, 4'h0);

        // Random phase. It checks the DUT against the reference model, with glitches and
        // occasional resets.
        m_d = 4'h0; m_jk = 4'hF; m_rs = 4'h0; m_both = 4'h0;
        for (int n = 0; n < 300; n++) begin
            vd = 4'($urandom); vj = 4'($urandom); vk = 4'($urandom);
            vr = 4'($urandom); vs = 4'($urandom);
            do_rst = ($urandom_range(0, 24) == 0);
            drive(vd, vj, vk, vr, vs);
            #2 drive(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            #2 drive(vd, vj, vk, vr, vs);
            if (do_rst) begin
                #1 rst_n = 1'b0;
                #1 check_all($sformatf("rnd%0d_rst", n), 4'h0, 4'h0, 4'h0, 4'h0);
                m_d = 4'h0; m_jk = 4'h0; m_rs = 4'h0; m_both = 4'h0;
                #1 rst_n = 1'b1;
            end
            @(posedge clk); #1;
            model_edge(vd, vj, vk, vr, vs);
            check_all($sformatf("rnd%0d", n), m_d, m_jk, m_rs, m_both);
            $display("rnd %0d D=%h J=%h K=%h R=%h S=%h rst=%0d -> q_d=%h q_jk=%h q_rs=%h both=%h",
                     n, vd, vj, vk, vr, vs, do_rst, q4_d, q4_jk, q4_rs, q4_both);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
